insexec_alu_seq: RTL and testbench
==================================

Name: insexec_alu_seq

Overview:
- Registered, handshaked integer execute unit; successor to the combinational OP-IMM compute slice.
- Decodes the full OP-IMM (7'b0010011) and OP (7'b0110011) sets: ADD/SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Shifts run on a multi-cycle iterative shifter. Output is a register-write request.
- Sits between the decode/operand-fetch stage and the register-file write port.

Parameters:
- XLEN, 32, datapath width (32 or 64); shamt width SW = log2(XLEN).
- SHIFT_STEP, 1, bit positions shifted per cycle in SHIFT state (power of two, 1..XLEN).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- in_op  in  7  decoded opcode
- in_funct3  in  3  decoded funct3
- in_funct7  in  7  decoded funct7 (OP only)
- in_rs1_val  in  XLEN  rs1 operand
- in_rs2_val  in  XLEN  rs2 operand (OP only)
- in_imm  in  XLEN  sign-extended I-immediate (OP-IMM only)
- in_rd  in  5  destination register index
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_w_op  out  1  register write enable
- out_rd  out  5  write register index
- out_val  out  XLEN  write value
- out_illegal  out  1  unsupported funct3/funct7/opcode

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0, out_w_op=0, out_rd=0, out_val=0, out_illegal=0; internal shift count=0.
  - Reset mid-SHIFT or mid-DONE discards the operation.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept when in_valid & in_ready.
- Operand B = in_imm for OP-IMM, in_rs2_val for OP.
- Non-shift accept: result computed and registered on the accept edge. Next state DONE; latency 1 cycle.
- Shift accept:
  - Latch operand and shamt = B[SW-1:0]; next state SHIFT.
  - Each SHIFT cycle moves the operand min(SHIFT_STEP, remaining) positions and decrements remaining.
  - At remaining==0, go to DONE.
  - shamt=0 goes directly to DONE with out_val=rs1.
  - Latency = 1 + ceil(shamt/SHIFT_STEP) cycles.
- DONE:
  - out_valid=1; outputs held stable until out_ready.
  - out_ready with no new accept -> IDLE, out_valid=0 next cycle.
  - out_ready with a same-cycle accept -> next op loaded (back-to-back, no bubble for non-shift ops).
- Arithmetic (all modulo 2^XLEN):
  - SUB only for OP with funct7=7'h20; ADD with funct7=0.
  - SLT is a signed compare, SLTU unsigned; result 0 or 1, zero-extended.
  - SRA and SRAI replicate bit XLEN-1.
  - OP-IMM has no SUBI; funct3=0 with any imm is ADDI. SLTIU compares against the sign-extended immediate as unsigned.
- Legality:
  - SLLI requires imm[11:SW]==0.
  - SRLI/SRAI require imm[11:SW]==0 except imm[10], which selects SRAI.
  - OP requires funct7 in {0, 7'h20}; 7'h20 is legal only with funct3 0 or 5.
  - Any other opcode is illegal.
  - Illegal: 1-cycle path to DONE with out_illegal=1, out_w_op=0, out_val=0, out_rd=in_rd.
- rd==0: result computed, out_w_op=0, out_illegal=0.
- in_* are don't-care when not accepted. in_valid held during SHIFT is ignored (in_ready=0).

Optional Feature:
- Macro INSEXEC_ALU_BARREL_SHIFT_EN.
- Defined:
  - Shifts use a single-cycle barrel shifter; SHIFT state unused and unreachable.
  - All legal ops have latency 1; SHIFT_STEP is ignored.
- Undefined:
  - Iterative shifter as above.

Test Plan:
- Reset: rst_n=0 asserted while in SHIFT with shamt=20 -> all outputs 0, state IDLE, in_ready=1 after release.
- ADDI: rs1=32'h7FFFFFFF, imm=1, rd=5 -> next cycle out_valid=1, out_val=32'h80000000, out_rd=5, out_w_op=1. Then SUB rs1=0, rs2=1 -> 32'hFFFFFFFF.
- SRAI, SHIFT_STEP=1: rs1=32'h80000000, imm=31 (imm[10]=1) -> out_val=32'hFFFFFFFF after 32 cycles; in_ready=0 throughout SHIFT. SLL with shamt=0 -> out_val=rs1 after 1 cycle.
- Back-pressure: XORI 32'hF0F0F0F0^32'hFFFFFFFF, out_ready=0 for 3 cycles -> out_val=32'h0F0F0F0F held stable. Then out_ready=1 with a new ORI offered -> accepted same cycle, new result the following cycle.
- Compares: SLT rs1=-1, rs2=1 -> 1. SLTU same operands -> 0. SLTIU rs1=5, imm=-1 -> 1.
- Illegal/rd0:
  - SLLI with imm=12'h020 -> out_illegal=1, out_w_op=0.
  - OP funct7=7'h20, funct3=4 -> illegal.
  - ADDI rd=0 -> out_valid=1, out_w_op=0, out_illegal=0.

Source files
------------

// File: rtl/insexec_alu_seq.sv
// insexec_alu_seq: registered, handshaked integer execute unit for the
// OP-IMM and OP instruction groups, producing a register-write request.
// Shifts normally run on an iterative shifter that moves SHIFT_STEP bit
// positions per cycle. Defining INSEXEC_ALU_BARREL_SHIFT_EN swaps in a
// single-cycle barrel shifter, after which the SHIFT state is never entered.
module insexec_alu_seq #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_op,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_w_op,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_val,
    output logic            out_illegal
);

    localparam int SW = $clog2(XLEN);

    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  F7_ZERO    = 7'h00;
    localparam logic [6:0]  F7_ALT     = 7'h20;
    localparam logic [SW:0] STEP_W     = (SW + 1)'(SHIFT_STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_LL = 2'd0,
        SH_RL = 2'd1,
        SH_RA = 2'd2
    } shkind_t;

    // Architectural state of the unit
    state_t          state_q,   state_d;
    shkind_t         shKind_q,  shKind_d;
    logic [SW-1:0]   shCnt_q,   shCnt_d;
    logic [XLEN-1:0] val_q,     val_d;
    logic [4:0]      rd_q,      rd_d;
    logic            wOp_q,     wOp_d;
    logic            illegal_q, illegal_d;

    // Decode results for the operation currently offered
    logic            isOpImm;
    logic            isOp;
    logic [XLEN-1:0] opB;
    logic [11:0]     immLow;
    logic [11:0]     immNoArith;
    logic            decIllegal;
    logic            decShift;
    shkind_t         decKind;
    logic [SW-1:0]   decShamt;
    logic [XLEN-1:0] decResult;

    // One iteration of the iterative shifter
    logic [SW:0]     stepAmt;
    logic [XLEN-1:0] stepRes;

    logic            accept;

    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    assign out_valid   = (state_q == DONE);
    assign out_w_op    = wOp_q & (state_q == DONE);
    assign out_rd      = rd_q;
    assign out_val     = val_q;
    assign out_illegal = illegal_q;

    // Decode the offered operation: legality, shift detection and the non-shift result
    always_comb begin
        isOpImm    = (in_op == OPC_OP_IMM);
        isOp       = (in_op == OPC_OP);
        opB        = isOpImm ? in_imm : in_rs2_val;
        immLow     = in_imm[11:0];
        immNoArith = immLow & ~12'h400;
        decShamt   = opB[SW-1:0];
        decIllegal = 1'b0;
        decShift   = 1'b0;
        decKind    = SH_LL;
        decResult  = '0;

        if (!isOpImm && !isOp) begin
            decIllegal = 1'b1;
        end else if (isOp && !((in_funct7 == F7_ZERO) ||
                               ((in_funct7 == F7_ALT) &&
                                ((in_funct3 == 3'd0) || (in_funct3 == 3'd5))))) begin
            decIllegal = 1'b1;
        end else begin
            case (in_funct3)
                3'd0: begin
                    if (isOp && (in_funct7 == F7_ALT)) begin
                        decResult = in_rs1_val - opB;
                    end else begin
                        decResult = in_rs1_val + opB;
                    end
                end
                3'd1: begin
                    decShift = 1'b1;
                    decKind  = SH_LL;
                    if (isOpImm && ((immLow >> SW) != 12'd0)) begin
                        decIllegal = 1'b1;
                    end
                end
                3'd2: begin
                    decResult = {{(XLEN-1){1'b0}}, ($signed(in_rs1_val) < $signed(opB))};
                end
                3'd3: begin
                    decResult = {{(XLEN-1){1'b0}}, (in_rs1_val < opB)};
                end
                3'd4: begin
                    decResult = in_rs1_val ^ opB;
                end
                3'd5: begin
                    decShift = 1'b1;
                    if (isOpImm) begin
                        decKind = immLow[10] ? SH_RA : SH_RL;
                        if ((immNoArith >> SW) != 12'd0) begin
                            decIllegal = 1'b1;
                        end
                    end else begin
                        decKind = (in_funct7 == F7_ALT) ? SH_RA : SH_RL;
                    end
                end
                3'd6: begin
                    decResult = in_rs1_val | opB;
                end
                default: begin
                    decResult = in_rs1_val & opB;
                end
            endcase
        end

        if (decIllegal) begin
            decShift  = 1'b0;
            decResult = '0;
        end
    end

    // Single iterative step: shift by min(SHIFT_STEP, remaining) positions
    always_comb begin
        stepAmt = ({1'b0, shCnt_q} < STEP_W) ? {1'b0, shCnt_q} : STEP_W;
        case (shKind_q)
            SH_RL:   stepRes = val_q >> stepAmt;
            SH_RA:   stepRes = XLEN'($signed(val_q) >>> stepAmt);
            default: stepRes = val_q << stepAmt;
        endcase
    end

`ifdef INSEXEC_ALU_BARREL_SHIFT_EN
    logic [XLEN-1:0] barrelRes;

    // Full-width shift of rs1 in one cycle
    always_comb begin
        case (decKind)
            SH_RL:   barrelRes = in_rs1_val >> decShamt;
            SH_RA:   barrelRes = XLEN'($signed(in_rs1_val) >>> decShamt);
            default: barrelRes = in_rs1_val << decShamt;
        endcase
    end
`endif

    // Next-state and result selection: advance shifts, retire results, load new ops
    always_comb begin
        state_d   = state_q;
        shKind_d  = shKind_q;
        shCnt_d   = shCnt_q;
        val_d     = val_q;
        rd_d      = rd_q;
        wOp_d     = wOp_q;
        illegal_d = illegal_q;

        case (state_q)
            SHIFT: begin
                val_d   = stepRes;
                shCnt_d = shCnt_q - stepAmt[SW-1:0];
                if (shCnt_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        if (accept) begin
            rd_d     = in_rd;
            shKind_d = decKind;
            shCnt_d  = '0;
            state_d  = DONE;
            if (decIllegal) begin
                val_d     = '0;
                wOp_d     = 1'b0;
                illegal_d = 1'b1;
            end else begin
                wOp_d     = (in_rd != 5'd0);
                illegal_d = 1'b0;
                if (decShift) begin
`ifdef INSEXEC_ALU_BARREL_SHIFT_EN
                    val_d = barrelRes;
`else
                    val_d   = in_rs1_val;
                    shCnt_d = decShamt;
                    if (decShamt != '0) begin
                        state_d = SHIFT;
                    end
`endif
                end else begin
                    val_d = decResult;
                end
            end
        end
    end

    // State registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shKind_q  <= SH_LL;
            shCnt_q   <= '0;
            val_q     <= '0;
            rd_q      <= 5'd0;
            wOp_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shKind_q  <= shKind_d;
            shCnt_q   <= shCnt_d;
            val_q     <= val_d;
            rd_q      <= rd_d;
            wOp_q     <= wOp_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_insexec_alu_seq.sv
// Scoreboard testbench for insexec_alu_seq: the driver pushes the reference
// model's expected write request on each accept; a monitor compares it
// against every cycle the DUT presents a result and pops it on handshake.
module tb_insexec_alu_seq;

    localparam int XLEN = 32;
    localparam int STEP = 1;
    localparam logic [6:0] OPI = 7'h13;
    localparam logic [6:0] OPR = 7'h33;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [6:0]      in_op = '0;
    logic [2:0]      in_funct3 = '0;
    logic [6:0]      in_funct7 = '0;
    logic [XLEN-1:0] in_rs1_val = '0;
    logic [XLEN-1:0] in_rs2_val = '0;
    logic [XLEN-1:0] in_imm = '0;
    logic [4:0]      in_rd = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic            out_w_op;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_val;
    logic            out_illegal;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] val;
        logic            wop;
        logic            ill;
        int              lat;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   checks = 0;
    int   errors = 0;
    bit   randomReady = 1'b0;

    insexec_alu_seq #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_w_op(out_w_op),
        .out_rd(out_rd), .out_val(out_val), .out_illegal(out_illegal)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model written from the instruction semantics
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] a, input logic [31:0] rs2,
                                   input logic [31:0] imm, input logic [4:0] rd);
        exp_t e;
        logic [31:0] b;
        int sh;
        bit isI, isR, bad, isShift, arith;
        isI = (op == OPI);
        isR = (op == OPR);
        b = isI ? imm : rs2;
        sh = int'(b[4:0]);
        isShift = (f3 == 3'd1) || (f3 == 3'd5);
        bad = 1'b0;
        if (!isI && !isR) bad = 1'b1;
        else if (isR && f7 != 7'h00 && !(f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) bad = 1'b1;
        else if (isI && f3 == 3'd1 && imm[11:5] != 7'd0) bad = 1'b1;
        else if (isI && f3 == 3'd5 && {imm[11], imm[9:5]} != 6'd0) bad = 1'b1;
        e.rd  = rd;
        e.ill = bad;
        e.wop = !bad && (rd != 5'd0);
        e.val = '0;
        e.lat = 1;
        if (!bad) begin
            arith = isR ? (f7 == 7'h20) : imm[10];
            case (f3)
                3'd0: e.val = (isR && arith) ? a - b : a + b;
                3'd1: e.val = a << sh;
                3'd2: e.val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: e.val = (a < b) ? 32'd1 : 32'd0;
                3'd4: e.val = a ^ b;
                3'd5: e.val = arith ? 32'($signed(a) >>> sh) : (a >> sh);
                3'd6: e.val = a | b;
                default: e.val = a & b;
            endcase
`ifndef INSEXEC_ALU_BARREL_SHIFT_EN
            if (isShift) e.lat = 1 + (sh + STEP - 1) / STEP;
`endif
        end
        return e;
    endfunction

    // Offer one operation, wait for acceptance and push its expected result
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [4:0] rd,
                                 output int waited, output exp_t e);
        e = model(op, f3, f7, a, rs2, imm, rd);
        in_op = op; in_funct3 = f3; in_funct7 = f7;
        in_rs1_val = a; in_rs2_val = rs2; in_imm = imm; in_rd = rd;
        in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 500) begin
                $display("[TB] FAIL accept_timeout: in_ready stuck at 0, required 1");
                $fatal(1, "[TB] accept timeout");
            end
        end
        @(posedge clk);
        expQ.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    // Count cycles until the result appears; in_ready must stay low while shifting
    task automatic waitResult(input int expLat);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < 300 && !seen) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1'b1;
            else if (expLat > 1) checkOutput("in_ready_during_shift", in_ready, 0);
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout: no out_valid after %0d cycles, required %0d", n, expLat);
        end else begin
            checkOutput("latency", n, expLat);
        end
    endtask

    task automatic doOp(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [4:0] rd);
        int w;
        exp_t e;
        applyStimulus(op, f3, f7, a, rs2, imm, rd, w, e);
        waitResult(e.lat);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

    // Monitor: compare presented result against scoreboard head, pop on handshake
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got rd=%0d val=%0h, required no result", out_rd, out_val);
            end else begin
                monE = expQ[0];
                checkOutput("out_rd", out_rd, monE.rd);
                checkOutput("out_val", out_val, monE.val);
                checkOutput("out_w_op", out_w_op, monE.wop);
                checkOutput("out_illegal", out_illegal, monE.ill);
                if (out_ready) void'(expQ.pop_front());
            end
        end
    end

    // Random consumer back-pressure during the randomized phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (randomReady) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int w;
        exp_t e;
        logic [11:0] i12;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int k;
        int drain;

        $display("[TB] reset checks");
        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_w_op", out_w_op, 0);
        checkOutput("reset_out_rd", out_rd, 0);
        checkOutput("reset_out_val", out_val, 0);
        checkOutput("reset_out_illegal", out_illegal, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] directed arithmetic");
        doOp(OPI, 3'd0, 7'h00, 32'h7FFFFFFF, 32'h0, 32'h1, 5'd5);
        doOp(OPR, 3'd0, 7'h20, 32'h0, 32'h1, 32'h0, 5'd6);
        doOp(OPI, 3'd5, 7'h00, 32'h80000000, 32'h0, sext12(12'h41F), 5'd7);
        doOp(OPR, 3'd1, 7'h00, 32'hDEADBEEF, 32'h20, 32'h0, 5'd8);
        doOp(OPR, 3'd5, 7'h00, 32'h80000000, 32'h4, 32'h0, 5'd9);
        doOp(OPR, 3'd2, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd10);
        doOp(OPR, 3'd3, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd11);
        doOp(OPI, 3'd3, 7'h00, 32'h5, 32'h0, sext12(12'hFFF), 5'd12);

        $display("[TB] illegal and rd0");
        doOp(OPI, 3'd1, 7'h00, 32'h1234, 32'h0, sext12(12'h020), 5'd13);
        doOp(OPR, 3'd4, 7'h20, 32'h1234, 32'h5, 32'h0, 5'd14);
        doOp(7'h37, 3'd0, 7'h00, 32'h1234, 32'h5, 32'h0, 5'd15);
        doOp(OPI, 3'd0, 7'h00, 32'h1234, 32'h0, 32'h1, 5'd0);

        $display("[TB] back-pressure and back-to-back");
        out_ready = 1'b0;
        applyStimulus(OPI, 3'd4, 7'h00, 32'hF0F0F0F0, 32'h0, 32'hFFFFFFFF, 5'd3, w, e);
        repeat (3) @(negedge clk);
        checkOutput("held_valid", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(OPI, 3'd6, 7'h00, 32'h00FF0000, 32'h0, 32'h0000000F, 5'd4, w, e);
        checkOutput("same_cycle_accept_wait", w, 0);
        waitResult(e.lat);
        @(posedge clk);
        #1;

        $display("[TB] reset during shift");
        out_ready = 1'b0;
        applyStimulus(OPI, 3'd1, 7'h00, 32'hA5A5A5A5, 32'h0, 32'd20, 5'd2, w, e);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("midshift_reset_out_valid", out_valid, 0);
        checkOutput("midshift_reset_out_val", out_val, 0);
        checkOutput("midshift_reset_out_rd", out_rd, 0);
        checkOutput("midshift_reset_out_w_op", out_w_op, 0);
        checkOutput("midshift_reset_out_illegal", out_illegal, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_in_ready", in_ready, 1);
        checkOutput("post_reset_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        doOp(OPR, 3'd7, 7'h00, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 5'd1);

        $display("[TB] randomized phase");
        randomReady = 1'b1;
        for (int n = 0; n < 200; n++) begin
            k = $urandom_range(0, 19);
            f3 = 3'($urandom_range(0, 7));
            i12 = 12'($urandom);
            f7 = 7'h00;
            if (k <= 8) begin
                op = OPI;
                if ((f3 == 3'd1 || f3 == 3'd5) && $urandom_range(0, 7) != 0) begin
                    i12 = {1'b0, (f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0, 5'd0, 5'($urandom)};
                end
            end else if (k <= 17) begin
                op = OPR;
                if ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) f7 = 7'h20;
                else if ($urandom_range(0, 9) == 0) f7 = 7'h20;
            end else if (k == 18) begin
                op = OPR;
                f7 = 7'($urandom);
            end else begin
                op = 7'($urandom);
            end
            applyStimulus(op, f3, f7, $urandom, $urandom, sext12(i12), 5'($urandom), w, e);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        randomReady = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain = 0;
        while (expQ.size() != 0 && drain < 400) begin
            @(posedge clk);
            drain++;
        end
        #1;
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
